// File: rtl/morse_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// morse_pkg : letter range, FSM states, unit counts, A-Z code table
// Rev 1.0
// ----------------------------------------------------------------
package morse_pkg;

  localparam logic [4:0] LETTER_MIN = 5'd1;
  localparam logic [4:0] LETTER_MAX = 5'd26;

  localparam logic [1:0] DOT_UNITS  = 2'd1;
  localparam logic [1:0] DASH_UNITS = 2'd3;
  localparam logic [1:0] SGAP_UNITS = 2'd1;
  localparam logic [1:0] LGAP_UNITS = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    SGAP = 2'd2,
    LGAP = 2'd3
  } state_e;

  // {len[2:0], pattern[3:0]}; pattern is left-justified, bit 1 = dash
  function automatic logic [6:0] morse_entry(input logic [4:0] code);
    logic [6:0] ent;
    case (code)
      5'd1:    ent = {3'd2, 4'b0100};
      5'd2:    ent = {3'd4, 4'b1000};
      5'd3:    ent = {3'd4, 4'b1010};
      5'd4:    ent = {3'd3, 4'b1000};
      5'd5:    ent = {3'd1, 4'b0000};
      5'd6:    ent = {3'd4, 4'b0010};
      5'd7:    ent = {3'd3, 4'b1100};
      5'd8:    ent = {3'd4, 4'b0000};
      5'd9:    ent = {3'd2, 4'b0000};
      5'd10:   ent = {3'd4, 4'b0111};
      5'd11:   ent = {3'd3, 4'b1010};
      5'd12:   ent = {3'd4, 4'b0100};
      5'd13:   ent = {3'd2, 4'b1100};
      5'd14:   ent = {3'd2, 4'b1000};
      5'd15:   ent = {3'd3, 4'b1110};
      5'd16:   ent = {3'd4, 4'b0110};
      5'd17:   ent = {3'd4, 4'b1101};
      5'd18:   ent = {3'd3, 4'b0100};
      5'd19:   ent = {3'd3, 4'b0000};
      5'd20:   ent = {3'd1, 4'b1000};
      5'd21:   ent = {3'd3, 4'b0010};
      5'd22:   ent = {3'd4, 4'b0001};
      5'd23:   ent = {3'd3, 4'b0110};
      5'd24:   ent = {3'd4, 4'b1001};
      5'd25:   ent = {3'd4, 4'b1011};
      5'd26:   ent = {3'd4, 4'b1100};
      default: ent = 7'd0;
    endcase
    return ent;
  endfunction

  function automatic logic [2:0] morse_len(input logic [4:0] code);
    logic [6:0] ent;
    ent = morse_entry(code);
    return ent[6:4];
  endfunction

  function automatic logic [3:0] morse_pat(input logic [4:0] code);
    logic [6:0] ent;
    ent = morse_entry(code);
    return ent[3:0];
  endfunction

  function automatic logic letter_valid(input logic [4:0] code);
    return (code >= LETTER_MIN) && (code <= LETTER_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/morse_letter_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------
// morse_letter_sequencer_if : letter request and keying/display bundle
// Rev 1.0
// ----------------------------------------------------------------
interface morse_letter_sequencer_if;

  logic       start;
  logic       abort;
  logic [4:0] letter_in;
  logic       morse_out;
  logic       busy;
  logic       done;
  logic       err;
  logic [4:0] disp_code;

  modport master (
    output start, abort, letter_in,
    input  morse_out, busy, done, err, disp_code
  );

  modport slave (
    input  start, abort, letter_in,
    output morse_out, busy, done, err, disp_code
  );

endinterface
`default_nettype wire

// File: rtl/morse_unit_timer.sv
`default_nettype none
// ----------------------------------------------------------------
// morse_unit_timer : one-cycle tick every UNIT_CYCLES, restartable by clr_i
// Rev 1.0
// ----------------------------------------------------------------
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int              CNT_W    = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UNIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/morse_letter_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------
// morse_letter_sequencer : keys one Morse letter on morse_out, holds code for display
// Rev 1.0
// ----------------------------------------------------------------
module morse_letter_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12500000
) (
  input  logic                     clk,
  input  logic                     rst,
  morse_letter_sequencer_if.slave  bus
);

  state_e     state_q, state_d;
  logic [3:0] pat_q, pat_d;
  logic [2:0] rem_q, rem_d;
  logic [1:0] units_q, units_d;
  logic [4:0] disp_q, disp_d;
  logic       morse_q, busy_q, done_q, err_q;
  logic       done_d, err_d;
  logic [1:0] need_units;
  logic       tick;
  logic       phase_end;
  logic       timer_clr;

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (timer_clr),
    .tick_o (tick)
  );

  // Every state entry restarts the unit timer so phases are whole units.
  assign timer_clr = (state_d != state_q) || (state_q == IDLE);

  always_comb begin
    need_units = DOT_UNITS;
    case (state_q)
      MARK:    need_units = pat_q[3] ? DASH_UNITS : DOT_UNITS;
      SGAP:    need_units = SGAP_UNITS;
      LGAP:    need_units = LGAP_UNITS;
      default: need_units = DOT_UNITS;
    endcase
  end

  assign phase_end = tick && (units_q == (need_units - 2'd1));

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rem_d   = rem_q;
    disp_d  = disp_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    units_d = tick ? (units_q + 2'd1) : units_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (letter_valid(bus.letter_in)) begin
            state_d = MARK;
            pat_d   = morse_pat(bus.letter_in);
            rem_d   = morse_len(bus.letter_in);
            disp_d  = bus.letter_in;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      MARK: begin
        if (phase_end) begin
          state_d = (rem_q == 3'd1) ? LGAP : SGAP;
          pat_d   = {pat_q[2:0], 1'b0};
          rem_d   = rem_q - 3'd1;
        end
      end
      SGAP: begin
        if (phase_end) begin
          state_d = MARK;
        end
      end
      LGAP: begin
        if (phase_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end

    if (state_d != state_q) begin
      units_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      rem_q   <= '0;
      units_q <= '0;
      disp_q  <= '0;
      morse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rem_q   <= rem_d;
      units_q <= units_d;
      disp_q  <= disp_d;
      morse_q <= (state_d == MARK);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.morse_out = morse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.disp_code = disp_q;

endmodule
`default_nettype wire

// File: doc/morse_letter_sequencer.md
Name: morse_letter_sequencer

Overview:
Sequences one Morse letter at a time from a 5-bit letter code (1=A … 26=Z). It drives the on/off keying line (LED/buzzer) with standard unit timing. It also holds the accepted letter code on a registered output, which feeds the letter-to-7-segment display decoder so the display shows the letter being keyed. It sits between the letter-entry logic (switches/keypad) and both the keying output and the display decoder.

Parameters:
UNIT_CYCLES, 12500000, clock cycles per Morse time unit (0.25 s at 50 MHz); legal range >= 1; benches use 4.

Ports:
clk  input  1  system clock; single clock domain; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request to key letter_in; sampled only in IDLE.
abort  input  1  cancel the letter in progress; returns to IDLE.
letter_in  input  5  letter code, 1=A … 26=Z; 0 and 27..31 are invalid.
morse_out  output  1  keying line; 1 = tone/LED on.
busy  output  1  high while a letter is being keyed, including the letter gap.
done  output  1  one-cycle pulse after the letter gap completes.
err  output  1  one-cycle pulse when start is given with an invalid code.
disp_code  output  5  last accepted letter code, driven to the display decoder.

Behaviour:
- All outputs are registered. Reset values: morse_out=0, busy=0, done=0, err=0, disp_code=0. Reset state is IDLE, and all counters are cleared.
- Timing rules: dot = 1 unit on; dash = 3 units on; gap between symbols = 1 unit off; letter gap after the last symbol = 3 units off; no symbol gap after the last symbol.
- FSM states:
  - IDLE -> MARK on a valid start (abort low).
  - MARK -> SGAP when the mark ends and more symbols remain.
  - MARK -> LGAP when the mark ends on the last symbol.
  - SGAP -> MARK after 1 unit.
  - LGAP -> IDLE after 3 units, pulsing done.
- Accept, cycle 0: start=1 with a valid code is sampled at the cycle-0 edge. From cycle 1: busy=1, morse_out=1, and disp_code=letter_in (latched and held until the next accepted start or reset).
- Symbols are sent MSB-first from the letter's pattern (bit 1 = dash), for LEN symbols (1..4). Pattern and LEN are latched at accept time, so later changes to letter_in have no effect.
- The final LGAP cycle is followed by one cycle with done=1, busy=0, state IDLE. A valid start in that same cycle is accepted, giving back-to-back letters.
- Unit counter: counts 0..UNIT_CYCLES-1 and produces a tick every UNIT_CYCLES cycles. It restarts at every state entry, so mark and gap lengths are exact multiples of UNIT_CYCLES. Counter width is $clog2(UNIT_CYCLES) with a minimum of 1; the unit count per phase is 2 bits.
- Invalid code: start with letter_in 0 or greater than 26 while IDLE gives err=1 for exactly one cycle. State, disp_code and morse_out are unchanged, and done is not pulsed.
- start while busy: ignored, with no err.
- abort while busy: the next cycle has morse_out=0, busy=0, state IDLE, and no done. disp_code keeps its value.
- abort and start in the same cycle while IDLE: abort wins and nothing is accepted.
- rst mid-letter: the next cycle has all outputs at their reset values, including disp_code=0.
- rst has priority over abort, and abort has priority over start.

Decomposition:
- Package morse_pkg:
  - the letter-code range constants LETTER_MIN=1 and LETTER_MAX=26;
  - a state enum {IDLE, MARK, SGAP, LGAP};
  - a constant lookup function morse_len(code) returning 3 bits;
  - a constant lookup function morse_pat(code) returning 4 bits, left-justified with MSB sent first;
  - DOT_UNITS=1, DASH_UNITS=3, SGAP_UNITS=1, LGAP_UNITS=3.
- Sub-module morse_unit_timer: a parameterised UNIT_CYCLES tick generator with a synchronous clear input. The FSM and symbol counter stay in the top level.

Test Plan:
- UNIT_CYCLES=4, start with letter E (5) at cycle 0 -> morse_out=1 in cycles 1-4, 0 in cycles 5-16; busy=1 in cycles 1-16; done=1 only in cycle 17; disp_code=5 from cycle 1.
- Letter A (1) -> morse_out=1 in cycles 1-4 and 9-20, 0 in cycles 5-8 and 21-32; done in cycle 33.
- Letter Z (26, dash dash dot dot) -> marks in cycles 1-12, 17-28, 33-36 and 41-44; done in cycle 57; start re-pulsed at cycle 20 is ignored.
- start with letter_in=0, then with letter_in=27 -> err=1 for one cycle each; busy stays 0; disp_code unchanged.
- Letter A accepted, then abort at cycle 10 -> morse_out=0 and busy=0 from cycle 11; no done; disp_code stays 1. Repeat with rst at cycle 10 -> all outputs 0 from cycle 11.
- Letter E keyed, then letter T (20) accepted during the done cycle (cycle 17) -> morse_out=1 in cycles 18-29; disp_code=20 from cycle 18.
